// File: rtl/dda_column_drawer.sv
// Column rasteriser: turns one DDA column record into a vertical strip of
// ceiling/wall/floor pixel writes into a double-buffered framebuffer.
module dda_column_drawer #(
  parameter int SCREEN_WIDTH = 320,
  parameter int SCREEN_HEIGHT = 240,
  parameter logic [7:0] CEIL_COLOR = 8'h11,
  parameter logic [7:0] FLOOR_COLOR = 8'h22
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        col_axis_tvalid,
  output logic        col_axis_tready,
  input  logic [38:0] col_axis_tdata,
  input  logic        col_axis_tlast,
  output logic [17:0] fb_addr_out,
  output logic [7:0]  fb_data_out,
  output logic        fb_we_out,
  output logic        fb_sel_out,
  output logic        frame_done_out,
  output logic        bad_col_out
);

  localparam int YB = $clog2(SCREEN_HEIGHT + 1);
  localparam int YW = (YB > 8) ? YB + 1 : 9;

  typedef enum logic {IDLE, DRAW} state_t;

  state_t state_q, state_d;
  logic rdy_q;
  logic [YW-1:0] row_q, top_q, bot_q;
  logic [16:0] addr_q;
  logic [7:0] wall_q, pix;
  logic last_q, sel_q, done_q, bad_q;

  logic [8:0] in_x;
  logic [7:0] in_h;
  logic [3:0] in_type;
  logic in_side, no_wall, x_bad, accept, last_row;
  logic [YW-1:0] h_ext, h_clamp, top_d, bot_d;
  logic wall_x_unused;

  assign in_x = col_axis_tdata[38:30];
  assign in_h = col_axis_tdata[29:22];
  assign in_type = col_axis_tdata[21:18];
  assign in_side = col_axis_tdata[17];
  assign wall_x_unused = ^col_axis_tdata[16:0];

  assign h_ext = YW'(in_h);
  assign h_clamp = (h_ext > YW'(SCREEN_HEIGHT)) ?
                   YW'(SCREEN_HEIGHT) : h_ext;
  assign no_wall = (in_h == 8'd0) || (in_type == 4'd0);
  // An empty slice is encoded as bot = top - 1 at the horizon.
  assign top_d = no_wall ? YW'(SCREEN_HEIGHT / 2) :
                 YW'(SCREEN_HEIGHT / 2) - (h_clamp >> 1);
  assign bot_d = no_wall ? YW'(SCREEN_HEIGHT / 2) - YW'(1) :
                 top_d + h_clamp - YW'(1);
  assign x_bad = {1'b0, in_x} >= 10'(SCREEN_WIDTH);

  assign col_axis_tready = rdy_q & rst_in & (state_q == IDLE);
  assign accept = col_axis_tvalid & col_axis_tready;
  assign last_row = row_q == YW'(SCREEN_HEIGHT - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !x_bad) state_d = DRAW;
      DRAW: if (last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix = wall_q;
    unique case (1'b1)
      (row_q < top_q): pix = CEIL_COLOR;
      (row_q > bot_q): pix = FLOOR_COLOR;
      default: pix = wall_q;
    endcase
  end

  assign fb_we_out = state_q == DRAW;
  assign fb_data_out = fb_we_out ? pix : 8'h00;
  assign fb_addr_out = fb_we_out ? {sel_q, addr_q} : 18'h0;
  assign fb_sel_out = sel_q;
  assign frame_done_out = done_q;
  assign bad_col_out = bad_q;

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      row_q <= '0;
      top_q <= '0;
      bot_q <= '0;
      addr_q <= '0;
      wall_q <= '0;
      last_q <= 1'b0;
      sel_q <= 1'b0;
      done_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q <= 1'b1;
      done_q <= 1'b0;
      if (accept) begin
        row_q <= '0;
        addr_q <= 17'(in_x);
        top_q <= top_d;
        bot_q <= bot_d;
        wall_q <= {in_type, in_side, 3'b000};
        last_q <= col_axis_tlast;
        if (x_bad) begin
          bad_q <= 1'b1;
          if (col_axis_tlast) begin
            done_q <= 1'b1;
            sel_q <= ~sel_q;
          end
        end
      end else if (state_q == DRAW) begin
        if (last_row) begin
          if (last_q) begin
            done_q <= 1'b1;
            sel_q <= ~sel_q;
          end
        end else begin
          row_q <= row_q + YW'(1);
          addr_q <= addr_q + 17'(SCREEN_WIDTH);
        end
      end
    end
  end

endmodule

// File: tb/tb_dda_column_drawer.sv
// Directed bench for dda_column_drawer: vector table of columns plus
// hand sequences for frame end, bad columns, backpressure and reset.
module tb_dda_column_drawer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tvalid, tready, tlast;
  logic [38:0] tdata;
  logic [17:0] fb_addr;
  logic [7:0] fb_data;
  logic fb_we, fb_sel, frame_done, bad_col;

  dda_column_drawer dut (
    .pixel_clk_in(clk),
    .rst_in(rst_n),
    .col_axis_tvalid(tvalid),
    .col_axis_tready(tready),
    .col_axis_tdata(tdata),
    .col_axis_tlast(tlast),
    .fb_addr_out(fb_addr),
    .fb_data_out(fb_data),
    .fb_we_out(fb_we),
    .fb_sel_out(fb_sel),
    .frame_done_out(frame_done),
    .bad_col_out(bad_col)
  );

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int a0;
  logic sel_exp;

  always @(posedge clk)
    if (rst_n && tvalid && tready) acc_cnt++;

  typedef struct {
    int x; int h; int t; int s;
    int top; int bot; int wall;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic drive(input int x, input int h, input int t,
                       input int s, input logic last);
    tvalid = 1'b1;
    tdata = {9'(x), 8'(h), 4'(t), 1'(s), 17'h0abcd};
    tlast = last;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (tready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no accept want accept");
    end
  endtask

  task automatic check_column(input int x, input int top, input int bot,
                              input int wall, input logic last,
                              input string tag);
    logic [7:0] pe;
    for (int y = 0; y < 240; y++) begin
      if (y < top) pe = 8'h11;
      else if (y > bot) pe = 8'h22;
      else pe = 8'(wall);
      chk($sformatf("%s_ctrl_y%0d", tag, y),
          {fb_we, tready, frame_done}, 3'b100);
      chk($sformatf("%s_addr_y%0d", tag, y),
          fb_addr, {sel_exp, 17'(x + 320 * y)});
      chk($sformatf("%s_data_y%0d", tag, y), fb_data, pe);
      @(negedge clk);
    end
    chk({tag, "_end"}, {fb_we, tready, frame_done}, {2'b01, last});
    if (last) sel_exp = ~sel_exp;
    chk({tag, "_sel"}, fb_sel, sel_exp);
  endtask

  initial begin
    vecs[0] = '{5, 10, 3, 1, 115, 124, 8'h38};
    vecs[1] = '{7, 255, 1, 0, 0, 239, 8'h10};
    vecs[2] = '{0, 0, 2, 1, 120, 119, 8'h28};
    vecs[3] = '{319, 20, 0, 1, 120, 119, 8'h08};
    vecs[4] = '{100, 240, 15, 1, 0, 239, 8'hf8};
    vecs[5] = '{10, 241, 4, 0, 0, 239, 8'h40};
    vecs[6] = '{12, 1, 5, 0, 120, 120, 8'h50};
    vecs[7] = '{13, 3, 6, 1, 119, 121, 8'h68};

    rst_n = 1'b0;
    tvalid = 1'b0;
    tlast = 1'b0;
    tdata = '0;
    sel_exp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {tready, fb_we, frame_done, bad_col, fb_sel}, 5'b0);
    chk("rst_addr", fb_addr, 18'h0);
    chk("rst_data", fb_data, 8'h00);
    rst_n = 1'b1;
    #1 chk("rst_release_rdy", tready, 1'b0);
    @(negedge clk);
    chk("rst_first_rdy", tready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].x, vecs[i].h, vecs[i].t, vecs[i].s, 1'b0);
      wait_accept();
      tvalid = 1'b0;
      check_column(vecs[i].x, vecs[i].top, vecs[i].bot,
                   vecs[i].wall, 1'b0, $sformatf("vec%0d", i));
    end

    for (int c = 0; c < 3; c++) begin
      drive(20 + c, 10, 3, 1, c == 2);
      wait_accept();
      tvalid = 1'b0;
      check_column(20 + c, 115, 124, 8'h38, c == 2,
                   $sformatf("frame%0d", c));
    end
    @(negedge clk);
    chk("frame_pulse_fall", {frame_done, fb_sel}, 2'b01);
    drive(30, 10, 3, 1, 1'b0);
    wait_accept();
    tvalid = 1'b0;
    chk("buf1_bit17", fb_addr[17], 1'b1);
    check_column(30, 115, 124, 8'h38, 1'b0, "buf1");

    drive(320, 10, 3, 1, 1'b0);
    wait_accept();
    chk("bad_drop", {fb_we, tready, frame_done, bad_col}, 4'b0101);
    drive(1, 10, 3, 1, 1'b0);
    wait_accept();
    tvalid = 1'b0;
    check_column(1, 115, 124, 8'h38, 1'b0, "after_bad");
    chk("bad_sticky", bad_col, 1'b1);

    drive(400, 10, 3, 1, 1'b1);
    wait_accept();
    tvalid = 1'b0;
    sel_exp = ~sel_exp;
    chk("bad_last", {fb_we, frame_done, bad_col}, 3'b011);
    chk("bad_last_sel", fb_sel, sel_exp);
    @(negedge clk);
    chk("bad_last_fall", {fb_we, frame_done}, 2'b00);

    a0 = acc_cnt;
    drive(50, 255, 1, 0, 1'b0);
    wait_accept();
    drive(51, 0, 7, 1, 1'b0);
    check_column(50, 0, 239, 8'h10, 1'b0, "bp_a");
    wait_accept();
    tvalid = 1'b0;
    check_column(51, 120, 119, 8'h78, 1'b0, "bp_b");
    chk("bp_accepts", acc_cnt - a0, 2);

    drive(9, 10, 3, 1, 1'b0);
    wait_accept();
    tvalid = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_row100", {fb_we, fb_addr}, {1'b1, sel_exp, 17'(9 + 32000)});
    rst_n = 1'b0;
    @(negedge clk);
    sel_exp = 1'b0;
    chk("mid_abort", {fb_we, tready, fb_addr}, 20'h0);
    repeat (2) @(negedge clk);
    chk("mid_hold", {fb_we, tready, bad_col}, 3'b000);
    rst_n = 1'b1;
    #1 chk("mid_release_rdy", tready, 1'b0);
    @(negedge clk);
    chk("mid_ready", {tready, fb_sel, fb_we}, 3'b100);
    drive(2, 10, 3, 1, 1'b0);
    wait_accept();
    tvalid = 1'b0;
    check_column(2, 115, 124, 8'h38, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dda_column_drawer.md
DDA_COLUMN_DRAWER -- requirements
Module: dda_column_drawer

Interface
- REQ-001 Parameter SCREEN_WIDTH, default 320, number of framebuffer columns.
- REQ-002 Parameter SCREEN_HEIGHT, default 240, number of framebuffer rows.
- REQ-003 Parameter CEIL_COLOR, default 8'h11, pixel value written above the wall slice.
- REQ-004 Parameter FLOOR_COLOR, default 8'h22, pixel value written below the wall slice.
- REQ-005 Clocking and reset: one clock; reset is synchronous and active-low.
- REQ-006 pixel_clk_in  input  1  sole clock; all state changes on its rising edge.
- REQ-007 rst_in  input  1  synchronous active-low reset.
- REQ-008 col_axis_tvalid  input  1  column record valid, from DDA-out FIFO receiver side.
- REQ-009 col_axis_tready  output  1  block accepts a record this cycle.
- REQ-010 col_axis_tdata  input  39  record: [38:30] column x, [29:22] line height, [21:18] wall type, [17] side, [16:0] wall_x fraction (carried, unused).
- REQ-011 col_axis_tlast  input  1  marks last column record of a frame.
- REQ-012 fb_addr_out  output  18  write address {buffer bit, y*SCREEN_WIDTH + x}.
- REQ-013 fb_data_out  output  8  pixel value.
- REQ-014 fb_we_out  output  1  write strobe, one pixel per cycle when high.
- REQ-015 fb_sel_out  output  1  buffer currently being drawn; display reads the other buffer.
- REQ-016 frame_done_out  output  1  one-cycle pulse when a tlast column finishes.
- REQ-017 bad_col_out  output  1  sticky flag: record with x >= SCREEN_WIDTH was received.

Function
- REQ-018 States: IDLE, DRAW; no other states.
- REQ-019 In IDLE, col_axis_tready SHALL be 1; in DRAW it SHALL be 0.
- REQ-020 A record is accepted only on a cycle with tvalid=1 and tready=1; x, height, type, side and tlast are latched on that edge.
- REQ-021 Height h > SCREEN_HEIGHT is clamped to SCREEN_HEIGHT; top = SCREEN_HEIGHT/2 - floor(h/2); bottom = top + h - 1.
- REQ-022 If h = 0 or wall type = 0, the column has no wall pixels: rows 0..SCREEN_HEIGHT/2-1 are ceiling and the remaining rows are floor.
- REQ-023 Wall pixel value = {wall type, side, 3'b000}.
- REQ-024 Pixel value per row: CEIL_COLOR for y < top; wall value for top <= y <= bottom; FLOOR_COLOR for y > bottom.
- REQ-025 Accepting a valid record moves IDLE->DRAW; in DRAW, fb_we_out=1 for exactly SCREEN_HEIGHT consecutive cycles.
- REQ-026 Writes cover y = 0..SCREEN_HEIGHT-1 in ascending order; the first write is on the cycle after acceptance.
- REQ-027 The address low part starts at x and adds SCREEN_WIDTH per row (no multiplier); fb_addr_out[17] = fb_sel_out.
- REQ-028 After the write for row SCREEN_HEIGHT-1, the next cycle is IDLE with tready=1; maximum throughput is one column per SCREEN_HEIGHT+1 cycles.
- REQ-029 When the final row of a tlast column is written, the next cycle SHALL pulse frame_done_out for 1 cycle and toggle fb_sel_out.
- REQ-030 A record with x >= SCREEN_WIDTH is accepted and produces no writes; state stays IDLE; bad_col_out sets.
- REQ-031 If that dropped record carries tlast, frame_done_out still pulses and fb_sel_out still toggles, on the cycle after acceptance.
- REQ-032 tvalid held high during DRAW is ignored; the record is accepted on the first IDLE cycle.
- REQ-033 fb_addr_out and fb_data_out are don't-care when fb_we_out=0.

Reset
- REQ-034 On any edge with rst_in=0: state=IDLE, fb_we_out=0, fb_addr_out=0, fb_data_out=0, fb_sel_out=0, frame_done_out=0, bad_col_out=0.
- REQ-035 While rst_in=0, col_axis_tready=0.
- REQ-036 Reset during DRAW aborts the column immediately with no further writes.
- REQ-037 The first tready=1 SHALL occur on the cycle after rst_in returns high.

Verification
- REQ-038 Single column: x=5, h=10, type=3, side=1 -> 240 writes; addr 5+320y; rows 0-114 = 8'h11, rows 115-124 = 8'h38, rows 125-239 = 8'h22; tready low for 240 cycles.
- REQ-039 Height clamp: h=255, type=1, side=0 -> all 240 rows = 8'h10; h=0 -> rows 0-119 = 8'h11 and rows 120-239 = 8'h22.
- REQ-040 Frame end: 320 back-to-back records, last with tlast -> one frame_done pulse after the final write; fb_sel goes 0->1; the next frame's addresses have bit 17 set.
- REQ-041 Bad column: x=320 with tlast=0 -> no writes, bad_col_out=1 and stays 1; the next valid record is accepted the following cycle.
- REQ-042 Reset mid-DRAW: rst_in=0 at row 100 -> fb_we=0 next cycle; after release, tready=1 and fb_sel=0.
- REQ-043 Backpressure: tvalid held high during DRAW -> no acceptance until IDLE; exactly one record is consumed per column.
